// File: rtl/mem_split_pkg.sv
// Shared types and width helpers for the split-transaction bus arbiter.
package mem_split_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic int calc_bw(input int data_width);
    return data_width / 8;
  endfunction

  // A single master still needs a one-bit id so the tracker has a legal width.
  function automatic int calc_iw(input int num_masters);
    return (num_masters > 1) ? $clog2(num_masters) : 1;
  endfunction

  function automatic int calc_cw(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/mem_split_resp_fifo.sv
// In-order tracker of the master ids whose reads are still awaiting a response.
module mem_split_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [ID_W-1:0]  id_i,
  input  logic             pop_i,
  output logic [ID_W-1:0]  id_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ID_W-1:0] mem_q [DEPTH];
  logic [ID_W-1:0] mem_d [DEPTH];
  logic            push_en, pop_en;

  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[PW-1:0] == rptr_q[PW-1:0]) && (wptr_q[PW] != rptr_q[PW]);
    count_o = CNT_W'(wptr_q - rptr_q);
    id_o    = mem_q[rptr_q[PW-1:0]];
    // Pop is judged on the pre-cycle occupancy, so a push into an empty tracker cannot be popped the same cycle.
    pop_en  = pop_i && !empty_o;
    push_en = push_i && (!full_o || pop_en);
    wptr_d  = push_en ? wptr_q + (PW+1)'(1) : wptr_q;
    rptr_d  = pop_en  ? rptr_q + (PW+1)'(1) : rptr_q;
    mem_d   = mem_q;
    if (push_en) mem_d[wptr_q[PW-1:0]] = id_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mem_split_arbiter.sv
// Round-robin N-master to 1-slave arbiter for the split-transaction memory bus,
// routing in-order read responses back to the issuing master.
module mem_split_arbiter
  import mem_split_pkg::*;
#(
  parameter int NUM_MASTERS     = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic [NUM_MASTERS-1:0]                      m_req_i,
  output logic [NUM_MASTERS-1:0]                      m_ack_o,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]           m_addr_i,
  input  logic [NUM_MASTERS-1:0]                      m_we_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]           m_wdata_i,
  input  logic [NUM_MASTERS*calc_bw(DATA_WIDTH)-1:0]  m_be_i,
  output logic [NUM_MASTERS-1:0]                      m_resp_o,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]           m_rdata_o,
  output logic                                        s_req_o,
  output logic [ADDR_WIDTH-1:0]                       s_addr_o,
  output logic                                        s_we_o,
  output logic [DATA_WIDTH-1:0]                       s_wdata_o,
  output logic [calc_bw(DATA_WIDTH)-1:0]              s_be_o,
  input  logic                                        s_ack_i,
  input  logic                                        s_resp_i,
  input  logic [DATA_WIDTH-1:0]                       s_rdata_i,
  output logic [calc_cw(MAX_OUTSTANDING)-1:0]         outstanding_o,
  output logic                                        resp_err_o
);

  localparam int BW = calc_bw(DATA_WIDTH);
  localparam int IW = calc_iw(NUM_MASTERS);
  localparam int CW = calc_cw(MAX_OUTSTANDING);

  state_e          state_q, state_d;
  logic [IW-1:0]   winner_q, winner_d, rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   pick, cand, head_id;
  int              cand_i;
  logic            found, push, pop, full, empty;

  // Rotating priority: first requester at or after rr_ptr, wrapping.
  always_comb begin
    pick   = '0;
    found  = 1'b0;
    cand   = '0;
    cand_i = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand_i = int'(rr_ptr_q) + k;
      if (cand_i >= NUM_MASTERS) cand_i = cand_i - NUM_MASTERS;
      cand = IW'(cand_i);
      if (!found && m_req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    rr_ptr_d  = rr_ptr_q;
    push      = 1'b0;
    m_ack_o   = '0;
    s_req_o   = 1'b0;
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_wdata_o = '0;
    s_be_o    = '0;
    case (state_q)
      ARB: begin
        if (found && !full) begin
          winner_d = pick;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        s_req_o   = 1'b1;
        s_addr_o  = m_addr_i[int'(winner_q)*ADDR_WIDTH +: ADDR_WIDTH];
        s_we_o    = m_we_i[winner_q];
        s_wdata_o = m_wdata_i[int'(winner_q)*DATA_WIDTH +: DATA_WIDTH];
        s_be_o    = m_be_i[int'(winner_q)*BW +: BW];
        if (s_ack_i) begin
          m_ack_o[winner_q] = 1'b1;
          push              = !m_we_i[winner_q];
          rr_ptr_d          = (winner_q == IW'(NUM_MASTERS - 1)) ? '0 : winner_q + IW'(1);
          state_d           = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    pop        = s_resp_i && !empty;
    resp_err_o = s_resp_i && empty;
    m_resp_o   = '0;
    if (pop) m_resp_o[head_id] = 1'b1;
    m_rdata_o  = {NUM_MASTERS{s_rdata_i}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB;
      winner_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  mem_split_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .ID_W  (IW),
    .CNT_W (CW)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .id_i    (winner_q),
    .pop_i   (pop),
    .id_o    (head_id),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding_o)
  );

endmodule
